// File: rtl/gda_error_monitor.sv
// gda_error_monitor: checks each GDA approximate sum against the exact sum.
// It gathers error-distance statistics over a window of WINDOW samples,
// then presents them through a valid/ready report handshake.
module gda_error_monitor #(
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in1,
    input  logic [7:0]         in2,
    input  logic [8:0]         approx_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W+8:0]   ed_sum,
    output logic [8:0]         ed_max
);

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               s1_valid_q, s1_valid_d;
    logic [8:0]         s1_ed_q, s1_ed_d;
    logic               s1_nz_q, s1_nz_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W+8:0]   ed_sum_q, ed_sum_d;
    logic [8:0]         ed_max_q, ed_max_d;

    logic [8:0]         exact;
    logic [8:0]         ed;
    logic               accept;
    logic               last_absorb;

    // Exact sum and absolute error distance of the sample currently presented
    always_comb begin
        exact = {1'b0, in1} + {1'b0, in2};
        if (exact >= approx_res) begin
            ed = exact - approx_res;
        end else begin
            ed = approx_res - exact;
        end
    end

    // A sample offered during clear is refused even though in_ready may read high
    assign in_ready    = (state_q == ACCUM) && (acc_cnt_q < WIN);
    assign accept      = in_valid && in_ready && !clear;
    assign last_absorb = s1_valid_q && (acc_cnt_q == WIN);

    // Next-state logic: stage-1 capture, stage-2 accumulation, ACCUM/REPORT control
    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        s1_valid_d  = accept;
        s1_ed_d     = s1_ed_q;
        s1_nz_d     = s1_nz_q;
        err_count_d = err_count_q;
        ed_sum_d    = ed_sum_q;
        ed_max_d    = ed_max_q;

        if (accept) begin
            s1_ed_d   = ed;
            s1_nz_d   = (ed != 9'd0);
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        if (s1_valid_q) begin
            err_count_d = err_count_q + CNT_W'(s1_nz_q);
            ed_sum_d    = ed_sum_q + (CNT_W+9)'(s1_ed_q);
            if (s1_ed_q > ed_max_q) begin
                ed_max_d = s1_ed_q;
            end
        end

        case (state_q)
            ACCUM: begin
                if (last_absorb) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    acc_cnt_d   = '0;
                    err_count_d = '0;
                    ed_sum_d    = '0;
                    ed_max_d    = '0;
                end
            end
            default: state_d = ACCUM;
        endcase

        if (clear) begin
            state_d     = ACCUM;
            acc_cnt_d   = '0;
            s1_valid_d  = 1'b0;
            s1_ed_d     = '0;
            s1_nz_d     = 1'b0;
            err_count_d = '0;
            ed_sum_d    = '0;
            ed_max_d    = '0;
        end
    end

    // State and statistics registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_ed_q     <= '0;
            s1_nz_q     <= 1'b0;
            err_count_q <= '0;
            ed_sum_q    <= '0;
            ed_max_q    <= '0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_ed_q     <= s1_ed_d;
            s1_nz_q     <= s1_nz_d;
            err_count_q <= err_count_d;
            ed_sum_q    <= ed_sum_d;
            ed_max_q    <= ed_max_d;
        end
    end

    assign out_valid = (state_q == REPORT);
    assign err_count = err_count_q;
    assign ed_sum    = ed_sum_q;
    assign ed_max    = ed_max_q;

endmodule

// File: tb/tb_gda_error_monitor.sv
// Testbench for gda_error_monitor with WINDOW=4.
// Expected reports are queued as samples are accepted.
// Each queued report is popped and compared when out_valid appears.
module tb_gda_error_monitor;

   localparam int WINDOW = 4;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in1;
   logic [7:0]       in2;
   logic [8:0]       approx_res;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W+8:0] ed_sum;
   logic [8:0]       ed_max;

   typedef struct packed {
      logic [31:0] err;
      logic [31:0] sum;
      logic [31:0] max;
   } report_t;

   report_t expQ[$];
   int modelCount;
   int modelErr;
   int modelSum;
   int modelMax;
   int checkCount = 0;
   int errorCount = 0;

   gda_error_monitor #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in1        (in1),
      .in2        (in2),
      .approx_res (approx_res),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_count  (err_count),
      .ed_sum     (ed_sum),
      .ed_max     (ed_max)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Count one comparison and report it if the values differ
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Start a fresh window in the reference model
   task automatic modelReset();
      modelCount = 0;
      modelErr   = 0;
      modelSum   = 0;
      modelMax   = 0;
   endtask

   // Offer one sample, wait for acceptance, then fold it into the model
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [8:0] approx);
      int waitCycles;
      int exact;
      int ed;
      waitCycles = 0;
      in1        = a;
      in2        = b;
      approx_res = approx;
      in_valid   = 1'b1;
      while (!in_ready && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exact = int'(a) + int'(b);
      ed    = (exact >= int'(approx)) ? exact - int'(approx) : int'(approx) - exact;
      modelCount++;
      if (ed != 0) modelErr++;
      modelSum += ed;
      if (ed > modelMax) modelMax = ed;
      if (modelCount == WINDOW) begin
         expQ.push_back('{err: modelErr, sum: modelSum, max: modelMax});
         modelReset();
      end
   endtask

   // Wait for out_valid, then compare the report against the queued expectation
   task automatic checkReport(input string tag);
      int edges;
      report_t e;
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checkOutput({tag, "_latency"}, edges, 32'd1);
      if (!out_valid) return;
      if (expQ.size() == 0) begin
         checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
         return;
      end
      e = expQ.pop_front();
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_err_count"}, 32'(err_count), e.err);
      checkOutput({tag, "_ed_sum"}, 32'(ed_sum), e.sum);
      checkOutput({tag, "_ed_max"}, 32'(ed_max), e.max);
   endtask

   // Accept the pending report with a single-cycle out_ready pulse
   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_hs_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_hs_err_count"}, 32'(err_count), 32'd0);
      checkOutput({tag, "_hs_ed_sum"}, 32'(ed_sum), 32'd0);
      checkOutput({tag, "_hs_ed_max"}, 32'(ed_max), 32'd0);
   endtask

   // Main stimulus sequence
   initial begin
      rst        = 1'b1;
      clear      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in1        = '0;
      in2        = '0;
      approx_res = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_err_count", 32'(err_count), 32'd0);
      checkOutput("reset_ed_sum", 32'(ed_sum), 32'd0);
      checkOutput("reset_ed_max", 32'(ed_max), 32'd0);

      // Window of exact samples
      for (int i = 0; i < WINDOW; i++) applyStimulus(8'd3, 8'd4, 9'd7);
      checkOutput("exact_in_ready_drop", 32'(in_ready), 32'd0);
      checkReport("exact");
      handshake("exact");

      // One real GDA error (ED 64) plus three exact samples
      applyStimulus(8'hFF, 8'h01, 9'h0C0);
      applyStimulus(8'd1, 8'd1, 9'd2);
      applyStimulus(8'd2, 8'd2, 9'd4);
      applyStimulus(8'd9, 8'd9, 9'd18);
      checkReport("gda64");
      handshake("gda64");

      // Approximation above exact (ED 16) mixed with ED 64, then backpressure
      applyStimulus(8'h10, 8'h10, 9'h030);
      applyStimulus(8'hFF, 8'h01, 9'h0C0);
      applyStimulus(8'd1, 8'd1, 9'd2);
      applyStimulus(8'd2, 8'd2, 9'd4);
      checkReport("mixed");
      in1        = 8'd7;
      in2        = 8'd7;
      approx_res = 9'd0;
      in_valid   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_err_count", 32'(err_count), 32'd2);
         checkOutput("bp_ed_sum", 32'(ed_sum), 32'd80);
         checkOutput("bp_ed_max", 32'(ed_max), 32'd64);
      end
      in_valid = 1'b0;
      handshake("mixed");

      // Clear after two samples, with an erroneous sample offered in the clear cycle
      applyStimulus(8'h10, 8'h10, 9'h030);
      applyStimulus(8'hFF, 8'h01, 9'h0C0);
      in1        = 8'hFF;
      in2        = 8'h01;
      approx_res = 9'h000;
      in_valid   = 1'b1;
      clear      = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      modelReset();
      checkOutput("clear_err_count", 32'(err_count), 32'd0);
      checkOutput("clear_ed_sum", 32'(ed_sum), 32'd0);
      checkOutput("clear_ed_max", 32'(ed_max), 32'd0);
      checkOutput("clear_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("clear_s1_flushed", 32'(ed_sum), 32'd0);
      applyStimulus(8'h80, 8'h80, 9'h0F0);
      applyStimulus(8'd1, 8'd2, 9'd3);
      applyStimulus(8'd5, 8'd5, 9'h00C);
      @(posedge clk);
      #1;
      checkOutput("clear_no_early_report", 32'(out_valid), 32'd0);
      applyStimulus(8'd0, 8'd0, 9'd0);
      checkReport("clear");
      handshake("clear");

      // Asynchronous reset in the middle of a cycle during REPORT
      applyStimulus(8'hFF, 8'h01, 9'h0C0);
      applyStimulus(8'd1, 8'd1, 9'd2);
      applyStimulus(8'd2, 8'd2, 9'd4);
      applyStimulus(8'd3, 8'd4, 9'd7);
      checkReport("prerst");
      #3;
      rst = 1'b1;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      checkOutput("rst_ed_sum", 32'(ed_sum), 32'd0);
      checkOutput("rst_ed_max", 32'(ed_max), 32'd0);
      #2;
      rst = 1'b0;
      modelReset();
      expQ.delete();
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rst_no_stale_report", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready_after", 32'(in_ready), 32'd1);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
